// File: rtl/switch_pkg.sv
// Shared definitions for the 4-port switch: port count, packet layout and
// the destination-to-request decode used by every ingress port.
package switch_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DATA_W    = 16;
  localparam int DEST_MSB  = 15;
  localparam int DEST_LSB  = 14;

  typedef logic [1:0] port_id_t;

  function automatic logic [NUM_PORTS-1:0] dest_onehot(input port_id_t port);
    dest_onehot       = '0;
    dest_onehot[port] = 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock packet FIFO with an explicit occupancy counter; refuses pushes
// while full and ignores pops while empty. Head word reads as zero when empty.
module sync_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // Full gates the push on pre-edge state, so a same-cycle pop cannot admit it.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop  && !o_empty;

  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ingress_port.sv
// Per-port input stage: buffers link packets, requests the destination
// output's arbiter for the head packet, pops on grant and counts refused words.
module ingress_port #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     ready_in,
  output logic [3:0]               req_out,
  input  logic                     grant_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         drop_cnt
);

  import switch_pkg::*;

  logic           w_full;
  port_id_t       w_dest;
  logic [CNT_W-1:0] r_drop_cnt;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (valid_in),
    .i_wr_data (data_in),
    .i_pop     (grant_in),
    .o_rd_data (data_out),
    .o_full    (w_full),
    .o_empty   (empty),
    .o_count   (count)
  );

  assign ready_in = !w_full;

  // Request is derived from the registered head, so it holds until popped.
  assign w_dest  = data_out[DEST_MSB:DEST_LSB];
  assign req_out = empty ? '0 : dest_onehot(w_dest);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (valid_in && !ready_in && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule
